// File: rtl/adc128s_pkg.sv
// Shared constants for the ADC128S SPI slave model.
// Holds default channel map and frame length.
package adc128s_pkg;

  localparam logic [2:0] CH_LFT_DEF   = 3'd0;
  localparam logic [2:0] CH_RGHT_DEF  = 3'd4;
  localparam logic [2:0] CH_STEER_DEF = 3'd5;
  localparam logic [2:0] CH_BATT_DEF  = 3'd6;

  localparam int FRAME_LEN = 16;
  localparam int CNT_W     = 5;

  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t FRAME_CNT = cnt_t'(FRAME_LEN);

endpackage

// File: rtl/spi_edge_sync.sv
// Synchronizes SCLK/SS_n/MOSI into clk and detects edges.
// Out: sclk_rise/fall, ss_fall/rise, mosi_s, ss_n_s.
module spi_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic SCLK,
  input  logic SS_n,
  input  logic MOSI,
  output logic sclk_rise,
  output logic sclk_fall,
  output logic ss_fall,
  output logic ss_rise,
  output logic mosi_s,
  output logic ss_n_s
);

  logic [2:0] sclk_ff;
  logic [2:0] ss_ff;
  logic [1:0] mosi_ff;

  // All flops reset high so a released reset with
  // idle bus produces no spurious edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_ff <= 3'b111;
      ss_ff   <= 3'b111;
      mosi_ff <= 2'b11;
    end else begin
      sclk_ff <= {sclk_ff[1:0], SCLK};
      ss_ff   <= {ss_ff[1:0], SS_n};
      mosi_ff <= {mosi_ff[0], MOSI};
    end
  end

  assign sclk_rise = sclk_ff[1] & ~sclk_ff[2];
  assign sclk_fall = ~sclk_ff[1] & sclk_ff[2];
  assign ss_rise   = ss_ff[1] & ~ss_ff[2];
  assign ss_fall   = ~ss_ff[1] & ss_ff[2];
  assign mosi_s    = mosi_ff[1];
  assign ss_n_s    = ss_ff[1];

endmodule

// File: rtl/adc128s_fc_model.sv
// Behavioural ADC128S SPI slave: returns a snapshot of the
// channel chosen by the previous complete 16-bit frame.
module adc128s_fc_model
  import adc128s_pkg::*;
#(
  parameter logic [2:0] CH_LFT   = CH_LFT_DEF,
  parameter logic [2:0] CH_RGHT  = CH_RGHT_DEF,
  parameter logic [2:0] CH_STEER = CH_STEER_DEF,
  parameter logic [2:0] CH_BATT  = CH_BATT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        SS_n,
  input  logic        SCLK,
  input  logic        MOSI,
  output logic        MISO,
  input  logic [11:0] ld_cell_lft,
  input  logic [11:0] ld_cell_rght,
  input  logic [11:0] steerPot,
  input  logic [11:0] batt
);

  logic sclk_rise;
  logic sclk_fall;
  logic ss_fall;
  logic ss_rise;
  logic mosi_s;
  logic ss_n_s;

  spi_edge_sync u_sync (
    .clk       (clk),
    .rst       (rst),
    .SCLK      (SCLK),
    .SS_n      (SS_n),
    .MOSI      (MOSI),
    .sclk_rise (sclk_rise),
    .sclk_fall (sclk_fall),
    .ss_fall   (ss_fall),
    .ss_rise   (ss_rise),
    .mosi_s    (mosi_s),
    .ss_n_s    (ss_n_s)
  );

  logic [2:0]  ch_ptr;
  logic [15:0] tx_shft;
  logic [15:0] rx_shft;
  cnt_t        bit_cnt;
  logic [11:0] ch_val;

  always_comb begin
    ch_val = 12'h000;
    if (ch_ptr == CH_LFT)
      ch_val = ld_cell_lft;
    else if (ch_ptr == CH_RGHT)
      ch_val = ld_cell_rght;
    else if (ch_ptr == CH_STEER)
      ch_val = steerPot;
    else if (ch_ptr == CH_BATT)
      ch_val = batt;
  end

  // SS_n edges win over any coincident SCLK edge.
  // bit_cnt != 0 doubles as "a rise has occurred",
  // so the leading SCLK fall does not shift tx.
  always_ff @(posedge clk) begin
    if (rst) begin
      ch_ptr  <= 3'd0;
      tx_shft <= 16'h0000;
      rx_shft <= 16'h0000;
      bit_cnt <= '0;
    end else if (ss_fall) begin
      tx_shft <= {4'b0000, ch_val};
      bit_cnt <= '0;
    end else if (ss_rise) begin
      if (bit_cnt == FRAME_CNT)
        ch_ptr <= rx_shft[13:11];
    end else if (!ss_n_s) begin
      if (sclk_rise) begin
        rx_shft <= 16'({rx_shft, mosi_s});
        if (bit_cnt != FRAME_CNT)
          bit_cnt <= bit_cnt + 1'b1;
      end else if (sclk_fall && bit_cnt != '0) begin
        tx_shft <= {tx_shft[14:0], 1'b0};
      end
    end
  end

  assign MISO = SS_n ? 1'bz : tx_shft[15];

endmodule

// File: tb/tb_adc128s_fc_model.sv
// Self-checking bench for adc128s_fc_model.
// Vector table, hand sequences and random frames vs model.
module tb_adc128s_fc_model;

  logic        clk = 1'b0;
  logic        rst;
  logic        SS_n;
  logic        SCLK;
  logic        MOSI;
  wire         miso_w;
  logic [11:0] lft;
  logic [11:0] rght;
  logic [11:0] steer;
  logic [11:0] batt;

  pullup (miso_w);

  always #5 clk = ~clk;

  adc128s_fc_model dut (
    .clk          (clk),
    .rst          (rst),
    .SS_n         (SS_n),
    .SCLK         (SCLK),
    .MOSI         (MOSI),
    .MISO         (miso_w),
    .ld_cell_lft  (lft),
    .ld_cell_rght (rght),
    .steerPot     (steer),
    .batt         (batt)
  );

  int checks = 0;
  int errors = 0;
  logic [2:0] mptr;

  typedef struct {
    logic [15:0] cmd;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[6];

  task automatic waitc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string name,
                     input logic [15:0] act,
                     input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  function automatic logic [11:0] chv(
    input logic [2:0] c);
    case (c)
      3'd0:    return lft;
      3'd4:    return rght;
      3'd5:    return steer;
      3'd6:    return batt;
      default: return 12'h000;
    endcase
  endfunction

  task automatic frame(input logic [15:0] cmd,
                       input int nbits,
                       input int chg_bit,
                       input logic [11:0] chg_val,
                       output logic [15:0] rx);
    rx = '0;
    SS_n = 1'b0;
    waitc(5);
    for (int i = 0; i < nbits; i++) begin
      SCLK = 1'b0;
      MOSI = cmd[15-i];
      if (i == chg_bit) batt = chg_val;
      waitc(5);
      rx[15-i] = miso_w;
      SCLK = 1'b1;
      waitc(5);
    end
    SS_n = 1'b1;
    waitc(6);
  endtask

  logic [15:0] rx;
  logic [15:0] exp;

  initial begin
    rst = 1'b1;
    SS_n = 1'b1;
    SCLK = 1'b1;
    MOSI = 1'b0;
    lft = 12'd400;
    rght = 12'd300;
    steer = 12'd200;
    batt = 12'h8FF;
    mptr = 3'd0;
    waitc(4);
    chk("miso_hiz_in_reset", {15'b0, miso_w}, 16'd1);
    rst = 1'b0;
    waitc(4);
    chk("miso_hiz_after_reset", {15'b0, miso_w}, 16'd1);

    frame(16'h0000, 16, -1, 12'h0, rx);
    chk("reset_ch0", rx, 16'd400);

    vecs[0] = '{16'h2000, 16'd400};
    vecs[1] = '{16'h2800, 16'd300};
    vecs[2] = '{16'h3000, 16'd200};
    vecs[3] = '{16'h1000, 16'h08FF};
    vecs[4] = '{16'h0000, 16'h0000};
    vecs[5] = '{16'h2800, 16'd400};
    for (int i = 0; i < 6; i++) begin
      frame(vecs[i].cmd, 16, -1, 12'h0, rx);
      chk($sformatf("vec%0d", i), rx, vecs[i].exp);
    end

    // Abort a channel-4 select; ch 5 must persist.
    frame(16'h2000, 10, -1, 12'h0, rx);
    frame(16'h3000, 16, -1, 12'h0, rx);
    chk("abort_keeps_ptr", rx, 16'd200);

    // batt changes mid-frame; snapshot holds.
    frame(16'h3000, 16, 5, 12'h123, rx);
    chk("batt_snapshot", rx, 16'h08FF);
    frame(16'h3000, 16, -1, 12'h0, rx);
    chk("batt_new", rx, 16'h0123);

    // Reset in the middle of a frame.
    SS_n = 1'b0;
    waitc(5);
    for (int i = 0; i < 8; i++) begin
      SCLK = 1'b0;
      MOSI = 1'b1;
      waitc(5);
      SCLK = 1'b1;
      waitc(5);
    end
    rst = 1'b1;
    waitc(2);
    SS_n = 1'b1;
    waitc(3);
    chk("miso_hiz_mid_rst", {15'b0, miso_w}, 16'd1);
    rst = 1'b0;
    waitc(4);
    chk("miso_hiz_post_rst", {15'b0, miso_w}, 16'd1);
    frame(16'h3800, 16, -1, 12'h0, rx);
    chk("post_rst_ch0", rx, 16'd400);
    frame(16'h0000, 16, -1, 12'h0, rx);
    chk("unmapped_ch7", rx, 16'h0000);

    // Random frames against the model.
    mptr = 3'd0;
    for (int n = 0; n < 50; n++) begin
      logic [15:0] cmd;
      int nb;
      lft   = 12'($urandom);
      rght  = 12'($urandom);
      steer = 12'($urandom);
      batt  = 12'($urandom);
      cmd = 16'($urandom);
      nb = ($urandom_range(0, 5) == 0) ?
           int'($urandom_range(1, 15)) : 16;
      exp = {4'b0000, chv(mptr)};
      frame(cmd, nb, -1, 12'h0, rx);
      if (nb == 16) begin
        chk($sformatf("rand%0d", n), rx, exp);
        mptr = cmd[13:11];
      end
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
